// File: rtl/ctr_kernel_multi.sv
// Multi-channel counter-service request kernel: issues count_to requests per enabled channel, then drains.
// Optional response tracking and drain timeout enabled by defining CTR_KERNEL_RSP_EN.
module ctr_kernel_multi #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned ARG_W    = 32,
  parameter int unsigned ID_W     = 8,
  parameter int unsigned DRAIN_CY = 10000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   done,
  output logic                   busy,
  input  logic [CNT_W-1:0]       count_to,
  input  logic [NCH-1:0]         chan_en,
  input  logic [NCH*ARG_W-1:0]   chan_idx,
  input  logic [NCH*ARG_W-1:0]   chan_inc,
  input  logic [NCH*ID_W-1:0]    chan_id,
  input  logic [NCH-1:0]         tx_full,
`ifdef CTR_KERNEL_RSP_EN
  input  logic [NCH-1:0]         rx_valid,
  output logic                   timeout,
`endif
  output logic [NCH-1:0]         tx_valid,
  output logic [NCH*ID_W-1:0]    tx_srcid,
  output logic [NCH*ID_W-1:0]    tx_dstid,
  output logic [NCH*ARG_W-1:0]   tx_arg0,
  output logic [NCH*ARG_W-1:0]   tx_arg1,
  output logic [NCH*ARG_W-1:0]   tx_arg2,
  output logic [NCH*CNT_W-1:0]   issued
);

  localparam int unsigned DW = $clog2(DRAIN_CY + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                     state, state_nx;
  logic [CNT_W-1:0]           count_q;
  logic [NCH-1:0]             en_q;
  logic [NCH-1:0][ARG_W-1:0]  idx_q, inc_q, arg0_q, arg1_q;
  logic [NCH-1:0][ID_W-1:0]   id_q, srcid_q;
  logic [NCH-1:0][CNT_W-1:0]  issued_q;
  logic [NCH-1:0]             tx_valid_q;
  logic [DW-1:0]              drain_q;
  logic                       done_q, busy_q;
  logic [NCH-1:0]             iss;
  logic                       all_fin;
  logic                       drain_hit;
  logic                       rx_all;

`ifdef CTR_KERNEL_RSP_EN
  logic [NCH-1:0][CNT_W-1:0]  rx_q;
  logic                       timeout_q;
`endif

  // Issue decisions, completion lookahead and next state
  always_comb begin
    iss       = '0;
    all_fin   = 1'b1;
    rx_all    = 1'b1;
    state_nx  = state;
    drain_hit = (drain_q == DW'(DRAIN_CY - 1));
    for (int c = 0; c < NCH; c++) begin
      iss[c] = (state == S_RUN) && start && en_q[c] &&
               (issued_q[c] < count_q) && !tx_full[c];
      if (en_q[c] && ((issued_q[c] + CNT_W'(iss[c])) < count_q))
        all_fin = 1'b0;
`ifdef CTR_KERNEL_RSP_EN
      if ((rx_q[c] + CNT_W'(rx_valid[c])) != issued_q[c])
        rx_all = 1'b0;
`endif
    end
`ifndef CTR_KERNEL_RSP_EN
    rx_all = 1'b0;
`endif
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN: begin
        if (!start)       state_nx = S_IDLE;
        else if (all_fin) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!start)                   state_nx = S_IDLE;
        else if (rx_all || drain_hit) state_nx = S_DONE;
      end
      S_DONE:  if (!start) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, configuration latch, issue counters and registered request messages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      count_q    <= '0;
      en_q       <= '0;
      idx_q      <= '0;
      inc_q      <= '0;
      id_q       <= '0;
      arg0_q     <= '0;
      arg1_q     <= '0;
      srcid_q    <= '0;
      issued_q   <= '0;
      tx_valid_q <= '0;
      drain_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      busy_q     <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
      done_q     <= (state_nx == S_DONE);
      tx_valid_q <= iss;
      if (state == S_IDLE && start) begin
        count_q  <= count_to;
        en_q     <= chan_en;
        idx_q    <= chan_idx;
        inc_q    <= chan_inc;
        id_q     <= chan_id;
        issued_q <= '0;
        drain_q  <= '0;
      end
      for (int c = 0; c < NCH; c++) begin
        if (iss[c]) begin
          issued_q[c] <= issued_q[c] + CNT_W'(1);
          srcid_q[c]  <= id_q[c];
          arg0_q[c]   <= idx_q[c];
          arg1_q[c]   <= inc_q[c];
        end
      end
      if (state == S_DRAIN && drain_q != DW'(DRAIN_CY))
        drain_q <= drain_q + DW'(1);
    end
  end

`ifdef CTR_KERNEL_RSP_EN
  // Response counting and drain timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start)
        rx_q <= '0;
      else if (state == S_RUN || state == S_DRAIN)
        for (int c = 0; c < NCH; c++)
          if (rx_valid[c]) rx_q[c] <= rx_q[c] + CNT_W'(1);
      if (state_nx == S_IDLE)
        timeout_q <= 1'b0;
      else if (state == S_DRAIN && state_nx == S_DONE && !rx_all)
        timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`endif

  assign done     = done_q;
  assign busy     = busy_q;
  assign tx_valid = tx_valid_q;
  assign tx_srcid = srcid_q;
  assign tx_dstid = srcid_q;
  assign tx_arg0  = arg0_q;
  assign tx_arg1  = arg1_q;
  assign tx_arg2  = '0;
  assign issued   = issued_q;

endmodule

// File: tb/tb_ctr_kernel_multi.sv
// Self-checking bench for ctr_kernel_multi: table-driven full runs plus stall, abort and reset sequences.
module tb_ctr_kernel_multi;
  localparam int unsigned NCH = 2, CNT_W = 20, ARG_W = 32, ID_W = 8, DRAIN_CY = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, start, done, busy;
  logic [CNT_W-1:0]     count_to;
  logic [NCH-1:0]       chan_en, tx_full, tx_valid;
  logic [NCH*ARG_W-1:0] chan_idx, chan_inc, tx_arg0, tx_arg1, tx_arg2;
  logic [NCH*ID_W-1:0]  chan_id, tx_srcid, tx_dstid;
  logic [NCH*CNT_W-1:0] issued;
`ifdef CTR_KERNEL_RSP_EN
  logic [NCH-1:0]       rx_valid;
  logic                 timeout;
  initial rx_valid = '0;
`endif

  ctr_kernel_multi #(.NCH(NCH), .CNT_W(CNT_W), .ARG_W(ARG_W), .ID_W(ID_W), .DRAIN_CY(DRAIN_CY)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .busy(busy),
    .count_to(count_to), .chan_en(chan_en), .chan_idx(chan_idx), .chan_inc(chan_inc),
    .chan_id(chan_id), .tx_full(tx_full),
`ifdef CTR_KERNEL_RSP_EN
    .rx_valid(rx_valid), .timeout(timeout),
`endif
    .tx_valid(tx_valid), .tx_srcid(tx_srcid), .tx_dstid(tx_dstid),
    .tx_arg0(tx_arg0), .tx_arg1(tx_arg1), .tx_arg2(tx_arg2), .issued(issued)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic [1:0]       en;
    int               p0, p1, is0, is1, busy_n, lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ID_W-1:0] exp_id(input int i, input int c);
    return ID_W'(32'h20 + i * 2 + c);
  endfunction
  function automatic logic [ARG_W-1:0] exp_idx(input int i, input int c);
    return ARG_W'(32'h1000_0000 + i * 256 + c);
  endfunction
  function automatic logic [ARG_W-1:0] exp_inc(input int i, input int c);
    return ARG_W'(32'h0000_A000 + i * 16 + c);
  endfunction

  task automatic set_cfg(input int i);
    chan_id  = {exp_id(i, 1), exp_id(i, 0)};
    chan_idx = {exp_idx(i, 1), exp_idx(i, 0)};
    chan_inc = {exp_inc(i, 1), exp_inc(i, 0)};
  endtask

  // Change every configuration input once the run has latched it
  task automatic scramble();
    chan_id  = ~chan_id;
    chan_idx = ~chan_idx;
    chan_inc = ~chan_inc;
    chan_en  = ~chan_en;
    count_to = CNT_W'(7);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int lat, bcnt, p0, p1;
    logic seen;
    set_cfg(i);
    count_to = v.cnt;
    chan_en  = v.en;
    tx_full  = '0;
    start    = 1'b1;
    lat = 0; bcnt = 0; p0 = 0; p1 = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      step();
      lat++;
      if (lat == 1) scramble();
      if (busy) bcnt++;
      for (int c = 0; c < NCH; c++) begin
        if (tx_valid[c]) begin
          if (c == 0) p0++; else p1++;
          check("srcid", 64'(tx_srcid[c*ID_W +: ID_W]), 64'(exp_id(i, c)));
          check("dstid", 64'(tx_dstid[c*ID_W +: ID_W]), 64'(exp_id(i, c)));
          check("arg0",  64'(tx_arg0[c*ARG_W +: ARG_W]), 64'(exp_idx(i, c)));
          check("arg1",  64'(tx_arg1[c*ARG_W +: ARG_W]), 64'(exp_inc(i, c)));
          check("arg2",  64'(tx_arg2[c*ARG_W +: ARG_W]), 64'd0);
        end
      end
      seen = done;
    end
    check("vec_done_seen", 64'(seen), 64'd1);
    check("vec_done_lat", 64'(lat), 64'(v.lat));
    check("vec_busy_cycles", 64'(bcnt), 64'(v.busy_n));
    check("vec_pulses0", 64'(p0), 64'(v.p0));
    check("vec_pulses1", 64'(p1), 64'(v.p1));
    check("vec_issued0", 64'(issued[0 +: CNT_W]), 64'(v.is0));
    check("vec_issued1", 64'(issued[CNT_W +: CNT_W]), 64'(v.is1));
    step();
    check("done_hold", 64'(done), 64'd1);
    check("done_txv", 64'(tx_valid), 64'd0);
    start = 1'b0;
    step();
    check("done_release", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] m0, m1;
    int dsamp;

    vecs[0] = '{cnt: 20'd5, en: 2'b11, p0: 5, p1: 5, is0: 5, is1: 5, busy_n: 21, lat: 22};
    vecs[1] = '{cnt: 20'd3, en: 2'b01, p0: 3, p1: 0, is0: 3, is1: 0, busy_n: 19, lat: 20};
    vecs[2] = '{cnt: 20'd0, en: 2'b11, p0: 0, p1: 0, is0: 0, is1: 0, busy_n: 17, lat: 18};
    vecs[3] = '{cnt: 20'd1, en: 2'b10, p0: 0, p1: 1, is0: 0, is1: 1, busy_n: 17, lat: 18};
    vecs[4] = '{cnt: 20'd2, en: 2'b00, p0: 0, p1: 0, is0: 0, is1: 0, busy_n: 17, lat: 18};

    rst_n = 1'b0; start = 1'b0; count_to = '0; chan_en = '0; tx_full = '0;
    chan_idx = '0; chan_inc = '0; chan_id = '0;
    repeat (3) step();
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_txv", 64'(tx_valid), 64'd0);
    check("rst_issued", 64'(issued), 64'd0);
    check("rst_arg0", 64'(tx_arg0), 64'd0);
    check("rst_srcid", 64'(tx_srcid), 64'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Back-pressure on channel 0 during RUN cycles 2..5
    set_cfg(10); count_to = CNT_W'(4); chan_en = 2'b11; tx_full = '0; start = 1'b1;
    m0 = '0; m1 = '0; dsamp = 0;
    for (int s = 1; s <= 27; s++) begin
      step();
      if (tx_valid[0]) m0[s] = 1'b1;
      if (tx_valid[1]) m1[s] = 1'b1;
      if (done && dsamp == 0) dsamp = s;
      if (s == 2) tx_full[0] = 1'b1;
      if (s == 6) tx_full[0] = 1'b0;
    end
    check("stall_mask0", 64'(m0), 64'h384);
    check("stall_mask1", 64'(m1), 64'h3C);
    check("stall_done_at", 64'(dsamp), 64'd25);
    check("stall_issued0", 64'(issued[0 +: CNT_W]), 64'd4);
    check("stall_issued1", 64'(issued[CNT_W +: CNT_W]), 64'd4);
    start = 1'b0;
    step();

    // Abort after two issues per channel
    set_cfg(11); count_to = CNT_W'(5); chan_en = 2'b11; start = 1'b1;
    step(); step(); step();
    check("abort_pre_txv", 64'(tx_valid), 64'd3);
    start = 1'b0;
    step();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_txv", 64'(tx_valid), 64'd0);
    check("abort_issued", 64'(issued), 64'({20'd2, 20'd2}));
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_done", 64'(done), 64'd0);
      check("abort_txv_hold", 64'(tx_valid), 64'd0);
    end
    check("abort_issued_hold", 64'(issued), 64'({20'd2, 20'd2}));

    // Reset in the middle of RUN
    set_cfg(12); count_to = CNT_W'(5); chan_en = 2'b11; start = 1'b1;
    step(); step();
    check("mid_pre_txv", 64'(tx_valid), 64'd3);
    rst_n = 1'b0;
    step();
    check("midrst_txv", 64'(tx_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_issued", 64'(issued), 64'd0);
    check("midrst_arg0", 64'(tx_arg0), 64'd0);
    rst_n = 1'b1; start = 1'b0;
    step();
    check("post_rst_txv", 64'(tx_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
